// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall control for a five-stage pipeline.
// Detects load-use hazards, sequences a multi-cycle multiply/divide unit,
// handles taken branches and instruction-memory wait states, and keeps a
// sticky fetch-timeout flag plus a saturating count of stalled cycles.
// Optional feature macro: HAZARD_MDU_EN. When defined, the MDU busy FSM and
// its down-counter are built. When undefined, the MDU inputs are ignored and
// mdu_busy/mdu_done are tied low.
module pipe_hazard_ctrl #(
  parameter int MDU_CYCLES    = 32,
  parameter int FETCH_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mdu_start,
  input  logic        id_mdu_dep,
  input  logic        id_branch_taken,
  input  logic        imem_ready,
  output logic        pc_en,
  output logic        IFID_en,
  output logic        IFID_clear,
  output logic        IDEX_clear,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic        fetch_err,
  output logic [15:0] stall_cnt
);

  localparam logic [9:0] LP_FETCH_LIMIT = 10'(FETCH_TIMEOUT);

  // Saturating increment of the 10-bit fetch wait counter.
  function automatic logic [9:0] sat_inc10(input logic [9:0] val);
    if (val == 10'h3FF) return val;
    return val + 10'd1;
  endfunction

  // Saturating increment of the 16-bit stall counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) return val;
    return val + 16'd1;
  endfunction

  logic       w_mdu_busy;
  logic       w_mdu_done;
  logic       w_mdu_stall;
  logic       w_load_use;
  logic [9:0] r_to_cnt;
  logic       r_fetch_err;
  logic [15:0] r_stall_cnt;
  logic [9:0] w_to_cnt_inc;

`ifdef HAZARD_MDU_EN
  localparam logic [7:0] LP_MDU_LOAD = 8'(MDU_CYCLES - 1);

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MDU_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_mdu_cnt;
  logic [7:0] w_mdu_cnt_nxt;

  // MDU state register and remaining-cycle counter; reset abandons any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_RUN;
      r_mdu_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_mdu_cnt <= w_mdu_cnt_nxt;
    end
  end

  // MDU next-state logic: a start while already busy is ignored.
  always_comb begin
    w_state_nxt   = r_state;
    w_mdu_cnt_nxt = r_mdu_cnt;
    w_mdu_busy    = 1'b0;
    w_mdu_done    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (ex_mdu_start) begin
          w_state_nxt   = S_MDU_BUSY;
          w_mdu_cnt_nxt = LP_MDU_LOAD;
        end
      end
      S_MDU_BUSY: begin
        w_mdu_busy = 1'b1;
        if (r_mdu_cnt == 8'd0) begin
          w_mdu_done  = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_mdu_cnt_nxt = r_mdu_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // A dependent instruction is held through the final (done) MDU cycle.
  assign w_mdu_stall = w_mdu_busy & id_mdu_dep;
`else
  logic w_mdu_unused;

  // Without the MDU the related inputs and parameter have no effect.
  assign w_mdu_unused = ^{ex_mdu_start, id_mdu_dep, 8'(MDU_CYCLES)};
  assign w_mdu_busy   = 1'b0;
  assign w_mdu_done   = 1'b0;
  assign w_mdu_stall  = 1'b0;
`endif

  // Register zero never carries a real dependency.
  assign w_load_use = ex_memread & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));

  // Pipeline control in strict priority: data hazard, branch, fetch wait, run.
  always_comb begin
    pc_en      = 1'b0;
    IFID_en    = 1'b0;
    IFID_clear = 1'b1;
    IDEX_clear = 1'b1;
    if (rst) begin
      if (w_load_use | w_mdu_stall) begin
        // The branch in ID re-resolves once the hazard clears, so keep it.
        pc_en      = 1'b0;
        IFID_en    = 1'b0;
        IFID_clear = 1'b0;
        IDEX_clear = 1'b1;
      end else if (id_branch_taken) begin
        pc_en      = 1'b1;
        IFID_en    = 1'b0;
        IFID_clear = 1'b1;
        IDEX_clear = 1'b0;
      end else if (!imem_ready) begin
        pc_en      = 1'b0;
        IFID_en    = 1'b0;
        IFID_clear = 1'b1;
        IDEX_clear = 1'b0;
      end else begin
        pc_en      = 1'b1;
        IFID_en    = 1'b1;
        IFID_clear = 1'b0;
        IDEX_clear = 1'b0;
      end
    end
  end

  assign w_to_cnt_inc = sat_inc10(r_to_cnt);

  // Consecutive fetch-wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt    <= 10'd0;
      r_fetch_err <= 1'b0;
    end else if (!imem_ready) begin
      r_to_cnt <= w_to_cnt_inc;
      if (w_to_cnt_inc >= LP_FETCH_LIMIT) begin
        r_fetch_err <= 1'b1;
      end
    end else begin
      r_to_cnt <= 10'd0;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 16'd0;
    end else if (!pc_en) begin
      r_stall_cnt <= sat_inc16(r_stall_cnt);
    end
  end

  assign mdu_busy  = w_mdu_busy;
  assign mdu_done  = w_mdu_done;
  assign fetch_err = r_fetch_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MDU_CYCLES, default 32: cycles a multiply/divide occupies the MDU; legal range 2..255.
REQ-002 Parameter FETCH_TIMEOUT, default 1023: consecutive imem_ready=0 cycles that flag a fetch error; legal range 1..1023.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset is asynchronous and active-low.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 ex_memread  in  1  instruction in EX is a load; ex_rt  in  5  its destination register.
REQ-007 ex_mdu_start  in  1  instruction in EX issues a multiply/divide this cycle.
REQ-008 id_mdu_dep  in  1  instruction in ID reads HI/LO or is itself an MDU op.
REQ-009 id_branch_taken  in  1  branch/jump resolved taken in ID.
REQ-010 imem_ready  in  1  instruction memory returns a valid word this cycle.
REQ-011 pc_en  out  1  PC register load enable.
REQ-012 IFID_en, IFID_clear  out  1 each  enable and synchronous clear of the IF/ID pipeline register.
REQ-013 IDEX_clear  out  1  inserts a bubble into ID/EX.
REQ-014 mdu_busy  out  1  FSM in MDU_BUSY; mdu_done  out  1  one-cycle pulse on the last MDU cycle.
REQ-015 fetch_err  out  1  sticky fetch-timeout flag; stall_cnt  out  16  saturating count of cycles with pc_en=0.

Function
REQ-016 FSM has exactly two states, RUN and MDU_BUSY; reset state is RUN.
REQ-017 RUN -> MDU_BUSY when ex_mdu_start=1; 8-bit down-counter loaded with MDU_CYCLES-1 on that edge.
REQ-018 In MDU_BUSY the counter decrements every cycle; when it equals 0, mdu_done=1 that cycle and the state returns to RUN on the next edge.
REQ-019 ex_mdu_start=1 while in MDU_BUSY is ignored (no reload, no state change).
REQ-020 load_use = ex_memread & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt), combinational.
REQ-021 mdu_stall = mdu_busy & id_mdu_dep, including the mdu_done cycle; a dependent instruction advances no earlier than the cycle after mdu_done.
REQ-022 Outputs are combinational from state and inputs, decided in strict priority order (REQ-023..026).
REQ-023 Priority 1, load_use | mdu_stall: pc_en=0, IFID_en=0, IFID_clear=0, IDEX_clear=1; a simultaneous id_branch_taken is ignored, since the branch re-resolves next cycle.
REQ-024 Priority 2, id_branch_taken: pc_en=1, IFID_en=0, IFID_clear=1, IDEX_clear=0.
REQ-025 Priority 3, imem_ready=0: pc_en=0, IFID_en=0, IFID_clear=1, IDEX_clear=0.
REQ-026 Otherwise: pc_en=1, IFID_en=1, IFID_clear=0, IDEX_clear=0.
REQ-027 IFID_en and IFID_clear are never both 1.
REQ-028 Fetch-timeout counter (10 bit) increments on each imem_ready=0 cycle and clears on imem_ready=1; when it reaches FETCH_TIMEOUT, fetch_err sets and stays 1 until reset.
REQ-029 stall_cnt increments on every cycle with pc_en=0 and holds at 16'hFFFF.
REQ-030 MDU operation runs concurrently with fetch stalls and branches; only mdu_stall blocks on it.

Reset
REQ-031 While rst=0: state RUN, MDU and timeout counters 0, fetch_err=0, stall_cnt=0, mdu_busy=0, mdu_done=0.
REQ-032 While rst=0: pc_en=0, IFID_en=0, IFID_clear=1, IDEX_clear=1.
REQ-033 Reset asserted mid-MDU operation abandons it; after release the FSM is in RUN with mdu_busy=0.

Configuration
REQ-034 Macro HAZARD_MDU_EN defined: MDU FSM, counter, mdu_stall and mdu_done behave as above.
REQ-035 HAZARD_MDU_EN undefined: no MDU state or counter; ex_mdu_start and id_mdu_dep ignored; mdu_busy=0, mdu_done=0; mdu_stall=0; all other behaviour unchanged.

Verification
REQ-036 ex_memread=1, ex_rt=5, id_rs=5 -> pc_en=0, IFID_en=0, IDEX_clear=1 for that cycle; ex_rt=0 with id_rs=0 -> no stall.
REQ-037 MDU_CYCLES=4, ex_mdu_start at cycle 0, id_mdu_dep=1 throughout -> mdu_busy cycles 1..4, mdu_done at cycle 4, stall cycles 1..4, pc_en=1 at cycle 5.
REQ-038 load_use=1 and id_branch_taken=1 together -> stall outputs, IFID_clear=0; next cycle with load_use=0 -> pc_en=1, IFID_clear=1.
REQ-039 imem_ready=0 for FETCH_TIMEOUT=3 cycles -> fetch_err=1 from the edge ending cycle 3 and stays 1 after imem_ready=1; stall_cnt=3.
REQ-040 rst=0 asserted during MDU_BUSY with counter=10 -> immediately mdu_busy=0, stall_cnt=0, IFID_clear=1; after release, state RUN.
REQ-041 Build without HAZARD_MDU_EN, ex_mdu_start=1, id_mdu_dep=1 -> mdu_busy stays 0 and pc_en=1.
